wb_reciprocal_pack: RTL and testbench
=====================================

Name: wb_reciprocal_pack

Overview:
Output stage of the white-balance pixel path. It takes per-channel frame averages and a target gray level, and computes each channel's reciprocal gain. It scales every pixel as pixel*k/avg with saturation, delays sync/de/coordinates to match, and packs the result into the 49-bit HDMI pixel bus. Sits after the statistics accumulator and before the next video module.

Parameters:
LATENCY, 4, pipeline depth from input pixel to o_pack; fixed arithmetic depth, must stay 4.
H_ACT, 1280, active width; x field is fixed at 11 bits.
V_ACT, 720, active height; y field is fixed at 10 bits.

Ports:
clk  in  1  pixel clock.
rstn  in  1  reset, asynchronous, active-low.
en  in  1  1 = output balanced RGB; 0 = output delayed original RGB.
k  in  8  target gray level (mean of channel averages), quasi-static.
avg_r, avg_g, avg_b  in  8 each  per-channel frame average, quasi-static.
i_hsync, i_vsync, i_de  in  1 each  input sync/data-enable.
i_r, i_g, i_b  in  8 each  input pixel.
i_x  in  11  pixel column.
i_y  in  10  pixel row.
o_pack  out  49  packed output {clk, hsync, vsync, de, r[7:0], g[7:0], b[7:0], x[10:0], y[9:0]}, MSB first.

Behaviour:
- Reciprocal function recip(a), 8b -> 32b:
  - a>=2: floor(2^32/a).
  - a=0 or a=1: 32'hFFFF_FFFF (saturated).
  - Implement as a 256-entry constant table or combinational divider; either is acceptable.
- Pipeline per channel c in {r,g,b}, 4 registered stages:
  - S1: p16 = i_c*k (16b unsigned); rc = recip(avg_c) registered.
  - S2: full48 = rc*p16 (48b unsigned).
  - S3: q = full48[47:32].
  - S4: out_c = (q >= 16'h00FF) ? 8'hFF : q[7:0].
- Sync path: {hsync,vsync,de}, {x,y} and original {r,g,b} each go through a 4-stage shift-register delay. The delay primitive is generic over WIDTH and DELAY; DELAY=0 means a wire.
- Output mux: o_pack RGB = en ? balanced : delayed original. en is sampled combinationally at the output, so a toggle takes effect on the same cycle.
- o_pack[48] = clk, passed through combinationally. All other fields come from registers.
- Reset (rstn=0, async):
  - All pipeline and delay registers clear to 0.
  - o_pack[47:0] = 0 until the first valid data has propagated, i.e. 4 clocks after rstn rises.
  - Reset mid-frame drops in-flight pixels; no recovery state.
- No handshake: one pixel in and one pixel out per clock, continuously, including blanking. Blanking pixels are processed identically.
- Changes to avg_*/k take effect for pixels entering S1 on the next edge. No glitch protection is required; upstream updates them at vsync.
- Widths: all arithmetic is unsigned, with no rounding (truncation only).

Test Plan:
- Unity gain: avg_r=128, k=128, en=1, i_r=200 -> out r=200 (recip=33554432), appearing exactly 4 clocks later with matching de/hsync/vsync/x/y.
- Saturation: avg_g=64, k=128, i_g=200 -> q=400 -> out g=8'hFF. Boundary: q=255 -> 8'hFF, q=254 -> 8'hFE.
- Degenerate average: avg_b=0, k=128, i_b=10 -> q=1279 -> 8'hFF; i_b=0 -> 0. Also avg_b=1 -> recip=32'hFFFFFFFF.
- Truncation: avg_r=3, k=100, i_r=3 -> full48 = 100*(2^32-1) -> out r=99.
- Bypass: en=0, random RGB stream -> o_pack RGB equals input RGB delayed 4 clocks. Toggling en mid-line switches the output on the same cycle.
- Reset: assert rstn low mid-line -> o_pack[47:0]=0 immediately (async). After release, the first input pixel appears at cycle 4 with the correct x/y and packing order.

Source files
------------

// File: rtl/wb_reciprocal_pack.sv
// White-balance output stage: divides each pixel by its channel average, scales it
// by the target gray level, and packs the result with delayed sync/coords onto the HDMI bus.

module wb_delay #(
  parameter int WIDTH = 1,
  parameter int DELAY = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  generate
    if (DELAY == 0) begin : g_wire
      assign dout_o = din_i;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DELAY];

      // NOTE: this small shift array is cleared on reset so the output bus reads zero
      // until real data has propagated; deep RAMs would normally be left unreset.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < DELAY; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= din_i;
          for (int i = 1; i < DELAY; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign dout_o = stage_q[DELAY-1];
    end
  endgenerate

endmodule

module wb_reciprocal_pack #(
  parameter int LATENCY = 4,
  parameter int H_ACT   = 1280,
  parameter int V_ACT   = 720
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic [7:0]                k,
  input  logic [7:0]                avg_r,
  input  logic [7:0]                avg_g,
  input  logic [7:0]                avg_b,
  input  logic                      i_hsync,
  input  logic                      i_vsync,
  input  logic                      i_de,
  input  logic [7:0]                i_r,
  input  logic [7:0]                i_g,
  input  logic [7:0]                i_b,
  input  logic [$clog2(H_ACT)-1:0]  i_x,
  input  logic [$clog2(V_ACT)-1:0]  i_y,
  output logic [48:0]               o_pack
);

  localparam int XYW = $clog2(H_ACT) + $clog2(V_ACT);

  // Averages of 0 and 1 saturate rather than divide by zero / overflow 32 bits.
  function automatic logic [31:0] recip(input logic [7:0] a);
    logic [32:0] divisor;
    divisor = (a < 8'd2) ? 33'd2 : {25'd0, a};
    recip   = (a < 8'd2) ? 32'hFFFF_FFFF : 32'(33'h1_0000_0000 / divisor);
  endfunction

  // Channel index 2 = red, 1 = green, 0 = blue.
  logic [2:0][7:0] pix;
  logic [2:0][7:0] avg;
  assign pix = {i_r, i_g, i_b};
  assign avg = {avg_r, avg_g, avg_b};

  logic [15:0] p16_q  [3];
  logic [31:0] rc_q   [3];
  logic [47:0] full_q [3];
  logic [15:0] qt_q   [3];
  logic [7:0]  bal_q  [3];

  // NOTE: all pipeline state uses non-blocking assignments so every stage samples
  // the previous stage's value from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < 3; c++) begin
        p16_q[c]  <= '0;
        rc_q[c]   <= '0;
        full_q[c] <= '0;
        qt_q[c]   <= '0;
        bal_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        p16_q[c]  <= {8'd0, pix[c]} * {8'd0, k};
        rc_q[c]   <= recip(avg[c]);
        full_q[c] <= {16'd0, rc_q[c]} * {32'd0, p16_q[c]};
        qt_q[c]   <= 16'(full_q[c] >> 32);
        bal_q[c]  <= (qt_q[c] >= 16'h00FF) ? 8'hFF : qt_q[c][7:0];
      end
    end
  end

  logic [2:0]     sync_dly;
  logic [23:0]    rgb_dly;
  logic [XYW-1:0] xy_dly;

  wb_delay #(.WIDTH(3), .DELAY(LATENCY)) u_sync_dly (
    .clk(clk), .rstn(rstn), .din_i({i_hsync, i_vsync, i_de}), .dout_o(sync_dly)
  );

  wb_delay #(.WIDTH(24), .DELAY(LATENCY)) u_rgb_dly (
    .clk(clk), .rstn(rstn), .din_i({i_r, i_g, i_b}), .dout_o(rgb_dly)
  );

  wb_delay #(.WIDTH(XYW), .DELAY(LATENCY)) u_xy_dly (
    .clk(clk), .rstn(rstn), .din_i({i_x, i_y}), .dout_o(xy_dly)
  );

  // en is deliberately unregistered so a mid-line toggle switches on the same cycle.
  assign o_pack = {clk, sync_dly,
                   en ? {bal_q[2], bal_q[1], bal_q[0]} : rgb_dly,
                   xy_dly};

endmodule

// File: tb/tb_wb_reciprocal_pack.sv
// Scoreboard bench for wb_reciprocal_pack: directed vectors with hand-computed gains,
// a bypass stream with en toggling, and async reset behaviour.

module tb_wb_reciprocal_pack;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  k = '0, avg_r = '0, avg_g = '0, avg_b = '0;
  logic        i_hsync = 1'b0, i_vsync = 1'b0, i_de = 1'b0;
  logic [7:0]  i_r = '0, i_g = '0, i_b = '0;
  logic [10:0] i_x = '0;
  logic [9:0]  i_y = '0;
  logic [48:0] o_pack;

  wb_reciprocal_pack dut (
    .clk(clk), .rstn(rstn), .en(en), .k(k),
    .avg_r(avg_r), .avg_g(avg_g), .avg_b(avg_b),
    .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
    .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_x(i_x), .i_y(i_y),
    .o_pack(o_pack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tag;
    logic [2:0]  sync;
    logic [23:0] orig;
    logic [23:0] bal;
    logic [10:0] x;
    logic [9:0]  y;
  } exp_t;

  typedef struct {
    logic [7:0]  k, ar, ag, ab, r, g, b, er, eg, eb;
    logic [2:0]  sync;
    logic [10:0] x;
    logic [9:0]  y;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[8];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive one pixel, captured at the next rising edge, and queue its expected output.
  task automatic drive(input vec_t v);
    exp_t e;
    @(posedge clk); #1;
    k = v.k; avg_r = v.ar; avg_g = v.ag; avg_b = v.ab;
    i_r = v.r; i_g = v.g; i_b = v.b;
    {i_hsync, i_vsync, i_de} = v.sync;
    i_x = v.x; i_y = v.y;
    e.tag = cyc; e.sync = v.sync; e.orig = {v.r, v.g, v.b};
    e.bal = {v.er, v.eg, v.eb}; e.x = v.x; e.y = v.y;
    sb.push_back(e);
  endtask

  // Monitor: a pixel captured after tag t leaves S4 at the edge where cyc becomes t+4.
  always @(negedge clk) begin
    if (rstn) begin
      while (sb.size() > 0 && sb[0].tag + 4 < cyc) begin
        mon_e = sb.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL lost pixel: tag %0d never checked, now cyc %0d", mon_e.tag, cyc);
      end
      if (sb.size() > 0 && sb[0].tag + 4 == cyc) begin
        mon_e = sb.pop_front();
        check("pix", o_pack[47:0],
              {mon_e.sync, (en ? mon_e.bal : mon_e.orig), mon_e.x, mon_e.y});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t v;
    //          k    ar   ag   ab   r    g    b    er   eg   eb   sync    x     y
    vecs[0] = '{128, 128, 128, 128, 200, 100, 0,   200, 100, 0,   3'b001, 0,    0  };
    vecs[1] = '{128, 128, 64,  128, 10,  200, 255, 10,  255, 255, 3'b011, 1,    1  };
    vecs[2] = '{128, 128, 128, 128, 255, 254, 1,   255, 254, 1,   3'b101, 640,  360};
    vecs[3] = '{128, 1,   1,   0,   0,   1,   10,  0,   127, 255, 3'b111, 1279, 719};
    vecs[4] = '{128, 0,   2,   0,   0,   3,   0,   0,   192, 0,   3'b000, 100,  719};
    vecs[5] = '{100, 3,   3,   200, 3,   1,   50,  99,  33,  24,  3'b001, 2,    3  };
    vecs[6] = '{0,   5,   5,   5,   77,  77,  77,  0,   0,   0,   3'b010, 1000, 500};
    vecs[7] = '{255, 255, 255, 2,   255, 0,   1,   254, 0,   127, 3'b110, 7,    9  };

    // Reset held with live inputs: output stays cleared.
    i_r = 8'hAA; i_g = 8'h55; i_b = 8'hC3; k = 8'd128;
    avg_r = 8'd1; avg_g = 8'd1; avg_b = 8'd1; en = 1'b1;
    i_hsync = 1'b1; i_de = 1'b1; i_x = 11'd5; i_y = 10'd6;
    #22;
    check("reset_hold", o_pack[47:0], 48'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Balanced path, back to back.
    for (int i = 0; i < 8; i++) drive(vecs[i]);

    // Bypass stream with k=0 so balanced output is 0; en toggles mid-line.
    en = 1'b0;
    for (int i = 0; i < 24; i++) begin
      v.k = 8'd0; v.ar = 8'd128; v.ag = 8'd128; v.ab = 8'd128;
      v.r = 8'($urandom) | 8'h01; v.g = 8'($urandom); v.b = 8'($urandom);
      v.er = 8'd0; v.eg = 8'd0; v.eb = 8'd0;
      v.sync = 3'($urandom); v.x = 11'(200 + i); v.y = 10'd42;
      drive(v);
      if (i == 8)  en = 1'b1;
      if (i == 14) en = 1'b0;
      if (i == 20) en = 1'b1;
    end
    repeat (5) @(negedge clk);

    // The clock itself rides on bit 48.
    @(posedge clk); #1;
    check("clk_bit_high", {47'd0, o_pack[48]}, 48'd1);
    @(negedge clk); #1;
    check("clk_bit_low", {47'd0, o_pack[48]}, 48'd0);

    // Mid-line async reset drops in-flight pixels.
    en = 1'b1;
    drive(vecs[0]);
    drive(vecs[2]);
    @(posedge clk); #1;
    rstn = 1'b0;
    sb.delete();
    #1;
    check("reset_async", o_pack[47:0], 48'd0);
    k = '0; avg_r = '0; avg_g = '0; avg_b = '0;
    i_r = '0; i_g = '0; i_b = '0;
    {i_hsync, i_vsync, i_de} = 3'b000; i_x = '0; i_y = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    v = '{128, 128, 128, 128, 1, 2, 3, 1, 2, 3, 3'b101, 1279, 719};
    drive(v);
    repeat (3) begin
      @(negedge clk);
      check("post_reset_zero", o_pack[47:0], 48'd0);
    end

    repeat (6) @(negedge clk);
    check("drain", 48'(sb.size()), 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
